// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } ps2_state_e;

   localparam int VALID_BIT      = 31;
   localparam int OVF_BIT        = 30;
   localparam int ERR_BIT        = 29;
   localparam int COUNT_LSB      = 8;
   localparam int PS2_FRAME_BITS = 11;

   // A frame is good when the stop bit is high and data plus parity carry odd weight.
   function automatic logic frame_ok(input logic [7:0] data, input logic par, input logic stop);
      return stop & (^{data, par});
   endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Scan-code FIFO: power-of-two depth, simultaneous push/pop, head byte reads 0 when empty.
module ps2_fifo
   import ps2_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   RSTN,
   input  logic                   i_push,
   input  logic [7:0]             i_data,
   input  logic                   i_pop,
   output logic [7:0]             o_head,
   output logic [$clog2(DEPTH):0] o_count,
   output logic                   o_empty,
   output logic                   o_ovf_evt
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_full;
   logic          w_do_pop;
   logic          w_do_push;

   assign o_empty   = (r_count == '0);
   assign w_full    = (r_count == (AW+1)'(DEPTH));
   assign w_do_pop  = i_pop & ~o_empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
   assign w_do_push = i_push & (~w_full | w_do_pop);
   assign o_ovf_evt = i_push & w_full & ~i_pop;

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!RSTN) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head  = o_empty ? 8'h00 : r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 device-to-host receiver with scan-code FIFO and MIO status word.
// Optional frame timeout enabled by defining PS2_TIMEOUT_EN.
//
// state     | meaning
// ST_IDLE   | waiting for a start bit (data low on a ps2_clk fall)
// ST_DATA   | shifting in 8 data bits, LSB first
// ST_PARITY | capturing the odd-parity bit
// ST_STOP   | checking stop bit and parity, then push or flag frame_err
module ps2_kbd_rx
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH     = 8,
   parameter int TIMEOUT_CYCLES = 200000
) (
   input  logic        clk,
   input  logic        RSTN,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   input  logic        rd,
   output logic [31:0] data_out,
   output logic        ready
);

   if (FIFO_DEPTH < 2 || FIFO_DEPTH > 8 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
       TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("ps2_kbd_rx: unsupported FIFO_DEPTH or TIMEOUT_CYCLES");
   end

   logic r_clk_s1, r_clk_s2, r_clk_s3;
   logic r_dat_s1, r_dat_s2;
   logic w_fall;
   logic w_timeout;

   ps2_state_e r_state, w_state_nxt;
   logic [2:0] r_bit_cnt, w_bit_cnt_nxt;
   logic [7:0] r_shift, w_shift_nxt;
   logic       r_par, w_par_nxt;
   logic       r_push, w_push_nxt;
   logic       r_ferr_evt, w_ferr_evt_nxt;
   logic       r_ovf, r_ferr;

   logic [7:0]                  w_head;
   logic [$clog2(FIFO_DEPTH):0] w_count;
   logic                        w_empty;
   logic                        w_ovf_evt;

   always_ff @(posedge clk) begin
      if (!RSTN) begin
         r_clk_s1 <= 1'b1;
         r_clk_s2 <= 1'b1;
         r_clk_s3 <= 1'b1;
         r_dat_s1 <= 1'b1;
         r_dat_s2 <= 1'b1;
      end else begin
         r_clk_s1 <= ps2_clk;
         r_clk_s2 <= r_clk_s1;
         r_clk_s3 <= r_clk_s2;
         r_dat_s1 <= ps2_data;
         r_dat_s2 <= r_dat_s1;
      end
   end

   assign w_fall = r_clk_s3 & ~r_clk_s2;

   always_ff @(posedge clk) begin
      if (!RSTN) begin
         r_state    <= ST_IDLE;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         r_par      <= 1'b0;
         r_push     <= 1'b0;
         r_ferr_evt <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_bit_cnt  <= w_bit_cnt_nxt;
         r_shift    <= w_shift_nxt;
         r_par      <= w_par_nxt;
         r_push     <= w_push_nxt;
         r_ferr_evt <= w_ferr_evt_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_bit_cnt_nxt  = r_bit_cnt;
      w_shift_nxt    = r_shift;
      w_par_nxt      = r_par;
      w_push_nxt     = 1'b0;
      w_ferr_evt_nxt = 1'b0;
      if (w_fall) begin
         case (r_state)
            ST_IDLE: begin
               if (!r_dat_s2) begin
                  w_state_nxt   = ST_DATA;
                  w_bit_cnt_nxt = '0;
               end
            end
            ST_DATA: begin
               w_shift_nxt   = {r_dat_s2, r_shift[7:1]};
               w_bit_cnt_nxt = r_bit_cnt + 3'd1;
               if (r_bit_cnt == 3'd7) begin
                  w_state_nxt = ST_PARITY;
               end
            end
            ST_PARITY: begin
               w_par_nxt   = r_dat_s2;
               w_state_nxt = ST_STOP;
            end
            ST_STOP: begin
               w_state_nxt = ST_IDLE;
               if (frame_ok(r_shift, r_par, r_dat_s2)) begin
                  w_push_nxt = 1'b1;
               end else begin
                  w_ferr_evt_nxt = 1'b1;
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end else if (w_timeout) begin
         w_state_nxt    = ST_IDLE;
         w_ferr_evt_nxt = 1'b1;
      end
   end

`ifdef PS2_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] r_to_cnt;

   always_ff @(posedge clk) begin
      if (!RSTN) begin
         r_to_cnt <= '0;
      end else if (w_fall || r_state == ST_IDLE) begin
         r_to_cnt <= '0;
      end else begin
         r_to_cnt <= r_to_cnt + TO_W'(1);
      end
   end

   assign w_timeout = (r_to_cnt == TO_W'(TIMEOUT_CYCLES));
`else
   assign w_timeout = 1'b0;
`endif

   ps2_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .RSTN      (RSTN),
      .i_push    (r_push),
      .i_data    (r_shift),
      .i_pop     (rd),
      .o_head    (w_head),
      .o_count   (w_count),
      .o_empty   (w_empty),
      .o_ovf_evt (w_ovf_evt)
   );

   // A fresh error in the read cycle outranks the read's clear.
   always_ff @(posedge clk) begin
      if (!RSTN) begin
         r_ovf  <= 1'b0;
         r_ferr <= 1'b0;
      end else begin
         if (w_ovf_evt) begin
            r_ovf <= 1'b1;
         end else if (rd) begin
            r_ovf <= 1'b0;
         end
         if (r_ferr_evt) begin
            r_ferr <= 1'b1;
         end else if (rd) begin
            r_ferr <= 1'b0;
         end
      end
   end

   always_comb begin
      data_out                  = '0;
      data_out[VALID_BIT]       = ~w_empty;
      data_out[OVF_BIT]         = r_ovf;
      data_out[ERR_BIT]         = r_ferr;
      data_out[COUNT_LSB +: 4]  = 4'(w_count);
      data_out[7:0]             = w_head;
   end

   assign ready = ~w_empty;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Self-checking bench for ps2_kbd_rx against a queue-based model of the FIFO and flags.
module tb_ps2_kbd_rx;

   localparam int DEPTH = 8;
   localparam int TO    = 300;
   localparam int HP    = 8;

   logic        clk      = 1'b0;
   logic        RSTN     = 1'b0;
   logic        ps2_clk  = 1'b1;
   logic        ps2_data = 1'b1;
   logic        rd       = 1'b0;
   logic [31:0] data_out;
   logic        ready;

   int n_checks = 0;
   int n_fail   = 0;

   byte unsigned m_q[$];
   bit           m_ovf  = 1'b0;
   bit           m_ferr = 1'b0;

   always #5 clk = ~clk;

   ps2_kbd_rx #(
      .FIFO_DEPTH     (DEPTH),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk      (clk),
      .RSTN     (RSTN),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .rd       (rd),
      .data_out (data_out),
      .ready    (ready)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] m_word();
      logic [31:0] w;
      w       = '0;
      w[31]   = (m_q.size() != 0);
      w[30]   = m_ovf;
      w[29]   = m_ferr;
      w[11:8] = 4'(m_q.size());
      if (m_q.size() != 0) w[7:0] = m_q[0];
      return w;
   endfunction

   task automatic chk_out(input string tag);
      chk({tag, " data_out"}, data_out, m_word());
      chk({tag, " ready"}, 32'(ready), 32'(m_q.size() != 0));
   endtask

   task automatic clk_n(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic m_rd();
      m_ovf  = 1'b0;
      m_ferr = 1'b0;
      if (m_q.size() != 0) void'(m_q.pop_front());
   endtask

   task automatic m_frame(input byte unsigned b, input bit good, input bit rd_same);
      bit popped;
      bit full_before;
      popped      = rd_same && (m_q.size() != 0);
      full_before = (m_q.size() == DEPTH);
      if (rd_same) m_rd();
      if (good) begin
         if (full_before && !popped) m_ovf = 1'b1;
         else m_q.push_back(b);
      end else begin
         m_ferr = 1'b1;
      end
   endtask

   // One PS/2 bit; optionally pulse rd exactly in the cycle the receiver pushes.
   task automatic send_bit(input bit b, input bit rd_at_push);
      ps2_data = b;
      clk_n(HP);
      ps2_clk = 1'b0;
      if (rd_at_push) begin
         clk_n(3);
         rd = 1'b1;
         clk_n(1);
         rd = 1'b0;
         clk_n(HP - 4);
      end else begin
         clk_n(HP);
      end
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input byte unsigned b, input bit bad_par, input bit bad_stop,
                             input bit rd_same);
      bit par;
      par = ~(^b) ^ bad_par;
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0);
      send_bit(par, 1'b0);
      send_bit(~bad_stop, rd_same);
      clk_n(HP);
      m_frame(b, !bad_par && !bad_stop, rd_same);
   endtask

   task automatic do_rd();
      rd = 1'b1;
      clk_n(1);
      rd = 1'b0;
      m_rd();
   endtask

   initial begin
      logic [7:0] last_head;
      int         r;

      clk_n(3);
      chk_out("reset");
      RSTN = 1'b1;
      clk_n(2);

      send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
      chk("good 1C", data_out, 32'h8000_011C);
      chk_out("good 1C model");
      do_rd();
      chk("good 1C pop", data_out, 32'h0000_0000);

      send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
      chk("bad parity", data_out, 32'h2000_0000);
      do_rd();
      chk("bad parity clear", data_out, 32'h0000_0000);

      for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b0);
      chk("overflow word", data_out, 32'hC000_0801);
      for (int i = 0; i < 8; i++) begin
         chk("overflow drain head", 32'(data_out[7:0]), 32'(i + 1));
         do_rd();
         chk_out("overflow drain");
      end

      for (int i = 0; i < DEPTH; i++) send_frame(8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
      send_frame(8'h55, 1'b0, 1'b0, 1'b1);
      chk("full rd+push count", 32'(data_out[11:8]), 32'd8);
      chk("full rd+push ovf", 32'(data_out[30]), 32'd0);
      chk_out("full rd+push");
      last_head = 8'h00;
      for (int i = 0; i < DEPTH; i++) begin
         last_head = data_out[7:0];
         do_rd();
         chk_out("full rd+push drain");
      end
      chk("last popped", 32'(last_head), 32'h55);

`ifdef PS2_TIMEOUT_EN
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
      clk_n(TO + 10);
      m_ferr = 1'b1;
      chk("timeout ferr", 32'(data_out[29]), 32'd1);
      chk_out("timeout");
      send_frame(8'h2A, 1'b0, 1'b0, 1'b0);
      chk_out("after timeout 2A");
      do_rd();
`endif

      while (m_q.size() != 0) do_rd();
      do_rd();
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
      RSTN = 1'b0;
      clk_n(1);
      RSTN = 1'b1;
      m_q.delete();
      m_ovf  = 1'b0;
      m_ferr = 1'b0;
      chk("midframe reset word", data_out, 32'h0);
      chk("midframe reset ready", 32'(ready), 32'd0);
      send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
      chk("resync 1C", data_out, 32'h8000_011C);
      do_rd();

      for (int it = 0; it < 60; it++) begin
         r = int'($urandom_range(0, 9));
         if (r < 3) begin
            do_rd();
         end else begin
            send_frame(8'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 11) == 0),
                       1'b0);
         end
         chk_out("random");
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
